// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit: CPU request/response handshake on one
// side and the DataMemory word port on the other.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; the requester holds req_* stable while req_valid is
// high and not yet accepted. resp_valid is a single-cycle pulse that cannot be
// stalled, and resp_err/resp_rdata are meaningful in that cycle.
interface load_store_unit_if #(
    parameter int Width = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    logic [2:0]       req_funct3;
    logic [31:0]      req_addr;
    logic [Width-1:0] req_wdata;
    logic             resp_valid;
    logic [Width-1:0] resp_rdata;
    logic             resp_err;
    logic             MemWrite;
    logic             MemRead;
    logic [7:0]       Addr;
    logic [Width-1:0] WrData;
    logic [Width-1:0] ReadData;

    // The load/store unit itself
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, ReadData,
        output req_ready, resp_valid, resp_rdata, resp_err,
               MemWrite, MemRead, Addr, WrData
    );

    // The CPU plus memory environment around the unit
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, ReadData,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               MemWrite, MemRead, Addr, WrData
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU request at a time, performs the memory
// access against a 256-word DataMemory (one-cycle registered read), does
// read-modify-write for byte/half stores, and returns an extended load result
// with a one-cycle response pulse. Illegal requests answer immediately with
// resp_err and never touch memory.
module load_store_unit #(
    parameter int Width = 32
) (
    input  logic                clk,
    input  logic                reset,
    load_store_unit_if.slave    bus,
    output logic [2:0]          dbgState
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD1  = 3'd1;
    localparam logic [2:0] RD2  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    logic [2:0]       state;
    logic             isStore;
    logic [2:0]       funct3;
    logic [9:0]       addrReg;
    logic [Width-1:0] dataReg;
    logic             errReg;
    logic [Width-1:0] rdataReg;
    logic             accept;
    logic             reqErr;

    // Byte/half/word extraction of a loaded word, sign- or zero-extended
    function automatic logic [Width-1:0] extractLoad(input logic [Width-1:0] word,
                                                     input logic [1:0] off,
                                                     input logic [2:0] f3);
        logic [7:0]  byteVal;
        logic [15:0] halfVal;
        case (off)
            2'd0:    byteVal = word[7:0];
            2'd1:    byteVal = word[15:8];
            2'd2:    byteVal = word[23:16];
            default: byteVal = word[31:24];
        endcase
        halfVal = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extractLoad = {{24{byteVal[7]}}, byteVal};
            3'b100:  extractLoad = {24'd0, byteVal};
            3'b001:  extractLoad = {{16{halfVal[15]}}, halfVal};
            3'b101:  extractLoad = {16'd0, halfVal};
            default: extractLoad = word;
        endcase
    endfunction

    // Replace the addressed byte or half of the old word with store data
    function automatic logic [Width-1:0] mergeStore(input logic [Width-1:0] word,
                                                    input logic [Width-1:0] wdata,
                                                    input logic [1:0] off,
                                                    input logic [2:0] f3);
        logic [Width-1:0] merged;
        merged = word;
        if (f3 == 3'b000) begin
            case (off)
                2'd0:    merged[7:0]   = wdata[7:0];
                2'd1:    merged[15:8]  = wdata[7:0];
                2'd2:    merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end else if (off[1]) begin
            merged[31:16] = wdata[15:0];
        end else begin
            merged[15:0] = wdata[15:0];
        end
        mergeStore = merged;
    endfunction

    assign accept = bus.req_valid && bus.req_ready;

    // Legality of the incoming request: size code, store size, alignment, range
    always_comb begin
        reqErr = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b100: reqErr = 1'b0;
            3'b001, 3'b101: reqErr = bus.req_addr[0];
            3'b010:         reqErr = (bus.req_addr[1:0] != 2'b00);
            default:        reqErr = 1'b1;
        endcase
        if (bus.req_store && bus.req_funct3[2]) reqErr = 1'b1;
        if (bus.req_addr[31:10] != 22'd0)       reqErr = 1'b1;
    end

    // Request sequencing FSM with latched request fields and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            isStore  <= 1'b0;
            funct3   <= 3'd0;
            addrReg  <= 10'd0;
            dataReg  <= '0;
            errReg   <= 1'b0;
            rdataReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        isStore <= bus.req_store;
                        funct3  <= bus.req_funct3;
                        addrReg <= bus.req_addr[9:0];
                        dataReg <= bus.req_wdata;
                        errReg  <= reqErr;
                        if (reqErr) begin
                            rdataReg <= '0;
                            state    <= RESP;
                        end else if (bus.req_store && bus.req_funct3 == 3'b010) begin
                            state <= WR;
                        end else begin
                            state <= RD1;
                        end
                    end
                end
                RD1: state <= RD2;
                RD2: begin
                    if (isStore) begin
                        dataReg <= mergeStore(bus.ReadData, dataReg, addrReg[1:0], funct3);
                        state   <= WR;
                    end else begin
                        rdataReg <= extractLoad(bus.ReadData, addrReg[1:0], funct3);
                        state    <= RESP;
                    end
                end
                WR: begin
                    rdataReg <= '0;
                    state    <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE) && !reset;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_err   = (state == RESP) && errReg;
    assign bus.resp_rdata = rdataReg;
    assign bus.MemRead    = (state == RD1) || (state == RD2);
    assign bus.MemWrite   = (state == WR);
    assign bus.Addr       = addrReg[9:2];
    assign bus.WrData     = (state == WR) ? dataReg : '0;
    assign dbgState       = state;
endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: behavioural DataMemory, reference memory
// model producing expected responses, response scoreboard and bus monitors.
module tb_load_store_unit;
    logic        clk;
    logic        rst;
    logic [2:0]  dbgState;
    int          total = 0;
    int          bad   = 0;
    int          cycleCnt = 0;
    int          wrTotal = 0;
    int          rdTotal = 0;
    logic [7:0]  lastWrAddr;
    logic [31:0] lastWrData;
    logic [31:0] lastRdata;
    logic [32:0] expQ[$];
    logic [31:0] mem    [256];
    logic [31:0] refMem [256];

    load_store_unit_if #(.Width(32)) lsuIf ();

    load_store_unit #(.Width(32)) dut (
        .clk      (clk),
        .reset    (rst),
        .bus      (lsuIf.slave),
        .dbgState (dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [31:0] initPattern(input int i);
        initPattern = 32'h9E3779B9 * (i + 1);
    endfunction

    // DataMemory: registered read, write on MemWrite, reloaded on reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= initPattern(i);
            lsuIf.ReadData <= 32'd0;
        end else begin
            if (lsuIf.MemWrite) begin
                mem[lsuIf.Addr] <= lsuIf.WrData;
                lastWrAddr <= lsuIf.Addr;
                lastWrData <= lsuIf.WrData;
                wrTotal    <= wrTotal + 1;
            end
            if (lsuIf.MemRead) begin
                lsuIf.ReadData <= mem[lsuIf.Addr];
                rdTotal <= rdTotal + 1;
            end
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic refInit();
        for (int i = 0; i < 256; i++) refMem[i] = initPattern(i);
    endtask

    // Reference model: returns {err, rdata}; applies successful stores to refMem
    function automatic logic [32:0] modelReq(input logic st, input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] wd);
        logic        isBad;
        logic [31:0] w, r, m;
        int          sh;
        isBad = 1'b0;
        case (f3)
            3'b000, 3'b100: isBad = 1'b0;
            3'b001, 3'b101: isBad = a[0];
            3'b010:         isBad = (a[1:0] != 2'b00);
            default:        isBad = 1'b1;
        endcase
        if (st && (f3 == 3'b100 || f3 == 3'b101)) isBad = 1'b1;
        if (a[31:10] != 22'd0) isBad = 1'b1;
        if (isBad) return {1'b1, 32'd0};
        w  = refMem[a[9:2]];
        sh = 8 * int'(a[1:0]);
        if (!st) begin
            r = w >> sh;
            case (f3)
                3'b000:  r = {{24{r[7]}}, r[7:0]};
                3'b100:  r = {24'd0, r[7:0]};
                3'b001:  r = {{16{r[15]}}, r[15:0]};
                3'b101:  r = {16'd0, r[15:0]};
                default: r = w;
            endcase
            return {1'b0, r};
        end
        if (f3 == 3'b000)      m = 32'h000000FF << sh;
        else if (f3 == 3'b001) m = 32'h0000FFFF << sh;
        else                   m = 32'hFFFFFFFF;
        refMem[a[9:2]] = (w & ~m) | ((wd << sh) & m);
        return {1'b0, 32'd0};
    endfunction

    // Scoreboard and bus-rule monitor, sampled mid-cycle
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst) begin
            checkVal("rd_wr_excl", {31'd0, lsuIf.MemRead & lsuIf.MemWrite}, 32'd0);
            if (!lsuIf.MemWrite) checkVal("wrdata_idle", lsuIf.WrData, 32'd0);
            if (lsuIf.resp_valid) begin
                checkVal("mem_quiet_resp", {30'd0, lsuIf.MemRead, lsuIf.MemWrite}, 32'd0);
                if (expQ.size() == 0) begin
                    checkVal("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkVal("resp_rdata", lsuIf.resp_rdata, e[31:0]);
                    checkVal("resp_err", {31'd0, lsuIf.resp_err}, {31'd0, e[32]});
                end
                lastRdata <= lsuIf.resp_rdata;
            end
        end
    end

    // Driver: issue one request, then check latency and memory traffic
    task automatic doReq(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        logic [32:0] e;
        int n, expLat, expRd, expWr, wrSnap, rdSnap;
        e = modelReq(st, f3, a, wd);
        if (e[32])                    begin expLat = 1; expRd = 0; expWr = 0; end
        else if (!st)                 begin expLat = 3; expRd = 2; expWr = 0; end
        else if (f3 == 3'b010)        begin expLat = 2; expRd = 0; expWr = 1; end
        else                          begin expLat = 4; expRd = 2; expWr = 1; end
        @(negedge clk);
        n = 0;
        while (!lsuIf.req_ready && n < 10) begin @(negedge clk); n++; end
        if (!lsuIf.req_ready) checkVal("ready_timeout", 32'd0, 32'd1);
        lsuIf.req_valid  = 1'b1;
        lsuIf.req_store  = st;
        lsuIf.req_funct3 = f3;
        lsuIf.req_addr   = a;
        lsuIf.req_wdata  = wd;
        expQ.push_back(e);
        wrSnap = wrTotal;
        rdSnap = rdTotal;
        @(posedge clk);
        #1;
        lsuIf.req_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!lsuIf.resp_valid && n < 8) begin @(negedge clk); n++; end
        if (!lsuIf.resp_valid) checkVal("resp_timeout", 32'd0, 32'd1);
        checkVal("latency", n, expLat);
        checkVal("ready_in_resp", {31'd0, lsuIf.req_ready}, 32'd0);
        checkVal("reads", rdTotal - rdSnap, expRd);
        checkVal("writes", wrTotal - wrSnap, expWr);
        #1;
    endtask

    logic [2:0] validF3 [5];

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        int          n, wrSnap;
        validF3[0] = 3'b000; validF3[1] = 3'b001; validF3[2] = 3'b010;
        validF3[3] = 3'b100; validF3[4] = 3'b101;
        refInit();
        lsuIf.req_valid  = 1'b0;
        lsuIf.req_store  = 1'b0;
        lsuIf.req_funct3 = 3'd0;
        lsuIf.req_addr   = 32'd0;
        lsuIf.req_wdata  = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_ready", {31'd0, lsuIf.req_ready}, 32'd0);
        checkVal("rst_resp_valid", {31'd0, lsuIf.resp_valid}, 32'd0);
        checkVal("rst_resp_err", {31'd0, lsuIf.resp_err}, 32'd0);
        checkVal("rst_rdata", lsuIf.resp_rdata, 32'd0);
        checkVal("rst_memctl", {30'd0, lsuIf.MemRead, lsuIf.MemWrite}, 32'd0);
        checkVal("rst_addr", {24'd0, lsuIf.Addr}, 32'd0);
        checkVal("rst_wrdata", lsuIf.WrData, 32'd0);
        checkVal("rst_state", {29'd0, dbgState}, 32'd0);
        rst = 1'b0;
        #1;
        checkVal("ready_after_rst", {31'd0, lsuIf.req_ready}, 32'd1);

        // Word store, then byte loads from the same word
        doReq(1'b1, 3'b010, 32'h10, 32'hAAAAAAAA);
        checkVal("sw_addr", {24'd0, lastWrAddr}, 32'd4);
        checkVal("sw_data", lastWrData, 32'hAAAAAAAA);
        checkVal("sw_mem", mem[4], 32'hAAAAAAAA);
        doReq(1'b0, 3'b000, 32'h13, 32'd0);
        checkVal("lb_13", lastRdata, 32'hFFFFFFAA);
        doReq(1'b0, 3'b100, 32'h13, 32'd0);
        checkVal("lbu_13", lastRdata, 32'h000000AA);

        // Half store read-modify-write, then word readback
        doReq(1'b1, 3'b001, 32'h12, 32'h00001234);
        checkVal("sh_mem", mem[4], 32'h1234AAAA);
        doReq(1'b0, 3'b010, 32'h10, 32'd0);
        checkVal("lw_10", lastRdata, 32'h1234AAAA);
        doReq(1'b0, 3'b001, 32'h12, 32'd0);
        doReq(1'b0, 3'b101, 32'h10, 32'd0);

        // Error cases
        doReq(1'b0, 3'b010, 32'h11, 32'd0);
        doReq(1'b1, 3'b010, 32'h400, 32'h1);
        doReq(1'b0, 3'b011, 32'h20, 32'd0);
        doReq(1'b1, 3'b100, 32'h20, 32'h1);
        doReq(1'b0, 3'b101, 32'h21, 32'd0);
        checkVal("err_rdata", lastRdata, 32'd0);

        // Reset during the write cycle of a byte store
        @(negedge clk);
        n = 0;
        while (!lsuIf.req_ready && n < 10) begin @(negedge clk); n++; end
        lsuIf.req_valid  = 1'b1;
        lsuIf.req_store  = 1'b1;
        lsuIf.req_funct3 = 3'b000;
        lsuIf.req_addr   = 32'h21;
        lsuIf.req_wdata  = 32'h55;
        @(posedge clk);
        #1;
        lsuIf.req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!lsuIf.MemWrite && n < 8) begin @(negedge clk); n++; end
        checkVal("sb_reached_wr", {31'd0, lsuIf.MemWrite}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        wrSnap = wrTotal;
        @(negedge clk);
        checkVal("abort_memwrite", {31'd0, lsuIf.MemWrite}, 32'd0);
        checkVal("abort_resp", {31'd0, lsuIf.resp_valid}, 32'd0);
        checkVal("abort_ready", {31'd0, lsuIf.req_ready}, 32'd0);
        checkVal("abort_state", {29'd0, dbgState}, 32'd0);
        repeat (2) @(negedge clk);
        checkVal("abort_no_write", wrTotal, wrSnap);
        rst = 1'b0;
        refInit();
        #1;
        checkVal("ready_post_abort", {31'd0, lsuIf.req_ready}, 32'd1);
        checkVal("abort_no_resp_q", expQ.size(), 32'd0);

        // Randomised mix of legal and illegal requests
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) a[12] = 1'b1;
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else                           f3 = validF3[$urandom_range(0, 4)];
            doReq(1'($urandom_range(0, 1)), f3, a, $urandom);
        end

        repeat (2) @(negedge clk);
        checkVal("queue_empty", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
